update_sequencer: RTL and testbench
===================================

# update_sequencer

Rate-update front end that sits directly upstream of the arbitrage container. Accepts edge-weight updates (src vertex, dst vertex, weight) from the host bus, buffers them in a small FIFO and presents them to the container one at a time. Each update triggers exactly one container run: pulse `container_reset`, hold `u_src`/`u_dst`/`u_e` stable, wait for `container_done`. Exposes status and a completed-run counter for host readback.

## Interface
- PRED_W, 6, vertex index width (matches `PRED_WIDTH`+1)
- WEIGHT_W, 32, edge weight width (matches `WEIGHT_WIDTH`+1), 1..32
- DEPTH, 8, FIFO entries, power of two, 2..64
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset; the block's only reset
- write  in  1  host write strobe, one cycle per access
- read  in  1  host read strobe
- address  in  2  register select
- writedata  in  32  host write data
- readdata  out  32  registered read data, valid the cycle after `read`
- container_reset  out  1  one-cycle start pulse to container
- container_done  in  1  container run finished (level, held until next start)
- src  out  PRED_W  Bellman source vertex register
- u_src, u_dst  out  PRED_W  current update endpoints
- u_e  out  WEIGHT_W  current update weight
- busy  out  1  high whenever state != IDLE

## Operation
- Write map: addr 0 stages `stg_src`=writedata[PRED_W-1:0], `stg_dst`=writedata[16+PRED_W-1:16] (no push). Addr 1 commits: pushes {stg_src, stg_dst, writedata[WEIGHT_W-1:0]}. Addr 2 loads `src`=writedata[PRED_W-1:0]. Addr 3 clears sticky `overflow`.
- Staging registers persist; repeated addr-1 writes push repeated endpoints with new weights.
- Push when count==DEPTH: entry dropped, `overflow` set, FIFO unchanged. Full is judged on pre-pop count, even if a pop occurs the same cycle.
- Read map: addr 0 = {run_count[15:0], 8'(count), 6'b0, overflow, busy}. Addr 1 = run_count[31:0]. Addr 2 = zero-extended `src`. Addr 3 = 0.
- FSM (IDLE, LOAD, START, ARM, WAIT):
  - IDLE: if count != 0, go to LOAD.
  - LOAD: pop head into u_src/u_dst/u_e registers; go to START.
  - START: container_reset=1 for this cycle only; go to ARM.
  - ARM: one-cycle guard while container clears its stale `container_done`; `container_done` is ignored; go to WAIT.
  - WAIT: on container_done=1, increment run_count (wraps at 2^32) and go to IDLE.
- u_src/u_dst/u_e change only on the LOAD edge. They stay stable from START through WAIT and until the next LOAD.
- `src` writes are accepted anytime. They take effect in the container on its next run, and the bench must not rely on mid-run changes.
- Simultaneous push and pop (not full): both happen, count unchanged.
- Reset (reset_n low, any state including mid-run): FIFO emptied, state IDLE, run abandoned, staging cleared.

## Timing
- Reset values: readdata=0, container_reset=0, src=0, u_src=0, u_dst=0, u_e=0, busy=0, overflow=0, run_count=0, count=0.
- Commit at cycle N (idle, empty FIFO):
  - count=1 visible at N+1, IDLE→LOAD.
  - N+2: LOAD, u_* update at its end.
  - N+3: START, container_reset=1.
  - N+4: ARM.
  - N+5: WAIT onward.
- container_done first sampled high at WAIT cycle M: run_count updated at M+1, state IDLE at M+1. If the FIFO is nonempty, next container_reset=1 at M+3.
- Minimum spacing between container_reset pulses: 5 cycles.
- busy is registered and high from LOAD through WAIT inclusive.
- readdata updates one cycle after the read strobe and holds until the next read.

## Test plan
- Reset: assert reset_n=0 mid-WAIT with 3 entries queued. Required: all outputs 0, count=0, no container_reset. After release, no run starts.
- Single update: write addr0=0x0002_0001, addr1=0x0000_0064. Required: container_reset pulses once at commit+3 with u_src=1, u_dst=2, u_e=100. Stub asserts done 10 cycles later. Required: busy falls, run_count=1.
- Stale done: stub holds container_done=1 from the previous run into START and clears it one cycle later. Required: the sequencer does not complete early, and the run ends only on the fresh done.
- Back-to-back: commit 3 updates in consecutive cycles. Required: three container_reset pulses in FIFO order, with u_* stable between LOAD edges, and run_count=3.
- Overflow: with the stub never asserting done, commit DEPTH+2 (10) entries. Required: count=8 (one entry popped into the active run, remaining DEPTH entries fill the FIFO), excess dropped, status bit1=1. Addr3 write clears it. Read addr0 shows count in [15:8].
- Readback: write addr2=5, then read addr2. Required: readdata=5 exactly one cycle after read. Read addr1 after 2 runs returns 2.

Source files
------------

// File: rtl/update_sequencer_if.sv
// Host register bus for the update sequencer: one-cycle write/read strobes, 2-bit register select,
// registered read data returned the cycle after the read strobe; no backpressure on this bus.
interface update_sequencer_if;
    logic        write;
    logic        read;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output write, read, address, writedata, input readdata);
    modport slave  (input write, read, address, writedata, output readdata);
endinterface

// File: rtl/update_sequencer.sv
// Queues host edge-weight updates and runs the container once per update; commit-to-start is 3 cycles.
// A commit into a full queue is dropped and flagged by sticky overflow; the host bus is never stalled.
module update_sequencer #(
    parameter int PRED_W   = 6,
    parameter int WEIGHT_W = 32,
    parameter int DEPTH    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    update_sequencer_if.slave   host,
    output logic                container_reset,
    input  logic                container_done,
    output logic [PRED_W-1:0]   src,
    output logic [PRED_W-1:0]   u_src,
    output logic [PRED_W-1:0]   u_dst,
    output logic [WEIGHT_W-1:0] u_e,
    output logic                busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * PRED_W + WEIGHT_W;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_ARM, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic [EW-1:0]         mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic [PRED_W-1:0]     stg_src_q, stg_dst_q, src_q;
    logic [PRED_W-1:0]     u_src_q, u_dst_q;
    logic [WEIGHT_W-1:0]   u_e_q;
    logic [31:0]           run_count_q, readdata_q, rd_mux;
    logic                  overflow_q, busy_q, creset_q;
    logic                  push_req, full, push, pop, run_done;
    logic [EW-1:0]         entry, head;

    assign push_req = host.write && (host.address == 2'd1);
    // Full is judged on the count before this cycle's pop.
    assign full     = (count_q == CW'(DEPTH));
    assign push     = push_req && !full;
    assign pop      = (state_q == S_LOAD);
    assign run_done = (state_q == S_WAIT) && container_done;
    assign entry    = {stg_src_q, stg_dst_q, host.writedata[WEIGHT_W-1:0]};
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (count_q != '0) state_d = S_LOAD;
            S_LOAD:  state_d = S_START;
            S_START: state_d = S_ARM;
            // Container is still clearing done from its previous run here.
            S_ARM:   state_d = S_WAIT;
            S_WAIT:  if (container_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (host.address)
            2'd0: rd_mux = {run_count_q[15:0], 8'(count_q), 6'b0, overflow_q, busy_q};
            2'd1: rd_mux = run_count_q;
            2'd2: rd_mux = 32'(src_q);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            stg_src_q   <= '0;
            stg_dst_q   <= '0;
            src_q       <= '0;
            u_src_q     <= '0;
            u_dst_q     <= '0;
            u_e_q       <= '0;
            run_count_q <= '0;
            readdata_q  <= '0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            creset_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            busy_q   <= (state_d != S_IDLE);
            creset_q <= (state_d == S_START);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q                   <= rd_ptr_q + 1'b1;
                {u_src_q, u_dst_q, u_e_q}  <= head;
            end
            if (host.write) begin
                case (host.address)
                    2'd0: begin
                        stg_src_q <= host.writedata[PRED_W-1:0];
                        stg_dst_q <= host.writedata[16+PRED_W-1:16];
                    end
                    2'd1: if (full) overflow_q <= 1'b1;
                    2'd2: src_q <= host.writedata[PRED_W-1:0];
                    default: overflow_q <= 1'b0;
                endcase
            end
            if (run_done) begin
                run_count_q <= run_count_q + 32'd1;
            end
            if (host.read) begin
                readdata_q <= rd_mux;
            end
        end
    end

    assign host.readdata   = readdata_q;
    assign container_reset = creset_q;
    assign busy            = busy_q;
    assign src             = src_q;
    assign u_src           = u_src_q;
    assign u_dst           = u_dst_q;
    assign u_e             = u_e_q;
endmodule

// File: tb/tb_update_sequencer.sv
// Bench for update_sequencer: container stub, pulse monitor and an expected-update scoreboard.
module tb_update_sequencer;
    localparam int PRED_W   = 6;
    localparam int WEIGHT_W = 32;
    localparam int DEPTH    = 8;

    typedef struct {
        int                  cyc;
        logic [PRED_W-1:0]   s;
        logic [PRED_W-1:0]   d;
        logic [WEIGHT_W-1:0] e;
    } upd_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic container_reset, container_done, busy;
    logic [PRED_W-1:0]   src, u_src, u_dst;
    logic [WEIGHT_W-1:0] u_e;

    update_sequencer_if hb();

    update_sequencer #(.PRED_W(PRED_W), .WEIGHT_W(WEIGHT_W), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .host            (hb.slave),
        .container_reset (container_reset),
        .container_done  (container_done),
        .src             (src),
        .u_src           (u_src),
        .u_dst           (u_dst),
        .u_e             (u_e),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   pulse_cnt = 0;
    int   unstable_cnt = 0;
    int   exp_runs = 0;
    int   stub_delay = 10;
    logic stub_en = 1'b1;
    logic [PRED_W-1:0] stg_s = '0;
    logic [PRED_W-1:0] stg_d = '0;
    upd_t exp_q[$];
    upd_t obs_q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: records every start pulse; endpoints may only change on the edge that opens START.
    initial begin
        logic [2*PRED_W+WEIGHT_W-1:0] prev;
        upd_t o;
        prev = '0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (container_reset) begin
                    o.cyc = cyc; o.s = u_src; o.d = u_dst; o.e = u_e;
                    obs_q.push_back(o);
                    pulse_cnt++;
                end else if ({u_src, u_dst, u_e} != prev) begin
                    unstable_cnt++;
                end
            end
            prev = {u_src, u_dst, u_e};
        end
    end

    // Container stub: keeps done from the last run through START and ARM, drops it, raises it stub_delay cycles after start.
    initial begin
        int ctr;
        ctr = -1;
        container_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                container_done = 1'b0;
                ctr = -1;
            end else if (container_reset) begin
                ctr = 0;
            end else if (ctr >= 0) begin
                ctr++;
                if (ctr == 2) container_done = 1'b0;
                if (stub_en && ctr >= stub_delay) begin
                    container_done = 1'b1;
                    ctr = -1;
                end
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        hb.write = 1'b1; hb.address = a; hb.writedata = d;
        @(negedge clk);
        hb.write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        hb.read = 1'b1; hb.address = a;
        @(negedge clk);
        hb.read = 1'b0;
        d = hb.readdata;
    endtask

    task automatic stage(input logic [PRED_W-1:0] s, input logic [PRED_W-1:0] d);
        stg_s = s; stg_d = d;
        bus_write(2'd0, {10'b0, d, 10'b0, s});
    endtask

    task automatic push_commit(input logic [WEIGHT_W-1:0] w, input bit timed, input bit kept);
        upd_t e;
        e.cyc = timed ? cyc + 3 : -1; e.s = stg_s; e.d = stg_d; e.e = w;
        if (kept) exp_q.push_back(e);
        bus_write(2'd1, w);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int p0;
        upd_t o, e;
        @(negedge clk);
        checks++; if (container_reset !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_ctrl: creset=%b busy=%b want 0/0", container_reset, busy); end
        checks++; if ({u_src, u_dst, u_e, src} !== '0) begin failures++; $display("FAIL reset_regs: u_src=%0d u_dst=%0d u_e=%0d src=%0d want 0", u_src, u_dst, u_e, src); end
        checks++; if (hb.readdata !== 32'd0) begin failures++; $display("FAIL reset_readdata: got %h want 0", hb.readdata); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(2'd0, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL reset_status: got %h want 0", rd); end
        stub_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stage(PRED_W'(2*i+1), PRED_W'(2*i+2));
            push_commit(32'(10+i), 1'b0, 1'b1);
        end
        for (int k = 0; k < 20 && obs_q.size() < 1; k++) @(negedge clk);
        checks++;
        if (obs_q.size() < 1) begin
            failures++; $display("FAIL reset_first_pulse: got %0d pulses want 1", obs_q.size());
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if ({o.s, o.d, o.e} !== {e.s, e.d, e.e}) begin failures++; $display("FAIL reset_first_upd: got %0d/%0d/%0d want %0d/%0d/%0d", o.s, o.d, o.e, e.s, e.d, e.e); end
        end
        repeat (6) @(negedge clk);
        bus_read(2'd0, rd);
        checks++; if (rd !== 32'h0000_0301) begin failures++; $display("FAIL midrun_status: got %h want 00000301", rd); end
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || container_reset !== 1'b0) begin failures++; $display("FAIL midrun_reset_ctrl: busy=%b creset=%b want 0/0", busy, container_reset); end
        checks++; if ({u_src, u_dst, u_e, src} !== '0 || hb.readdata !== 32'd0) begin failures++; $display("FAIL midrun_reset_regs: u=%0d/%0d/%0d rd=%h want zeros", u_src, u_dst, u_e, hb.readdata); end
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete(); obs_q.delete();
        stg_s = '0; stg_d = '0;
        p0 = pulse_cnt;
        repeat (20) @(negedge clk);
        checks++; if (pulse_cnt != p0 || busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle: pulses=%0d busy=%b want 0/0", pulse_cnt - p0, busy); end
        bus_read(2'd0, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL post_reset_status: got %h want 0", rd); end
        // Staging was cleared, so a bare commit carries endpoints 0/0.
        stub_en = 1'b1; stub_delay = 4;
        push_commit(32'd7, 1'b1, 1'b1);
        for (int k = 0; k < 20 && obs_q.size() < 1; k++) @(negedge clk);
        checks++;
        if (obs_q.size() < 1) begin
            failures++; $display("FAIL staging_clear_pulse: got no pulse want 1");
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if ({o.s, o.d, o.e} !== {e.s, e.d, e.e}) begin failures++; $display("FAIL staging_clear: got %0d/%0d/%0d want %0d/%0d/%0d", o.s, o.d, o.e, e.s, e.d, e.e); end
        end
        for (int k = 0; k < 30 && busy !== 1'b0; k++) @(negedge clk);
        exp_runs++;
    endtask

    task automatic test_single();
        logic [31:0] rd;
        int p0;
        upd_t o, e;
        stub_delay = 10;
        p0 = pulse_cnt;
        stage(6'd1, 6'd2);
        push_commit(32'h0000_0064, 1'b1, 1'b1);
        for (int k = 0; k < 20 && obs_q.size() < 1; k++) @(negedge clk);
        checks++;
        if (obs_q.size() < 1) begin
            failures++; $display("FAIL single_pulse: got no pulse want 1");
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if ({o.s, o.d, o.e} !== {e.s, e.d, e.e}) begin failures++; $display("FAIL single_upd: got %0d/%0d/%0d want %0d/%0d/%0d", o.s, o.d, o.e, e.s, e.d, e.e); end
            checks++; if (o.cyc != e.cyc) begin failures++; $display("FAIL single_latency: pulse at %0d want %0d", o.cyc, e.cyc); end
            for (int k = 0; k < 40 && busy !== 1'b0; k++) @(negedge clk);
            checks++; if (busy !== 1'b0 || cyc - o.cyc != 11) begin failures++; $display("FAIL single_busy_fall: %0d cycles after start want 11", cyc - o.cyc); end
        end
        exp_runs++;
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'(exp_runs)) begin failures++; $display("FAIL single_run_count: got %0d want %0d", rd, exp_runs); end
        checks++; if (pulse_cnt - p0 != 1) begin failures++; $display("FAIL single_pulse_count: got %0d want 1", pulse_cnt - p0); end
    endtask

    task automatic test_stale_done();
        int tfall;
        upd_t o, e;
        stub_delay = 4;
        tfall = -1;
        stage(6'd20, 6'd21);
        push_commit(32'd40, 1'b1, 1'b1);
        push_commit(32'd41, 1'b0, 1'b1);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 30 && obs_q.size() < 1; k++) @(negedge clk);
            checks++;
            if (obs_q.size() < 1) begin
                failures++; $display("FAIL stale_pulse%0d: no pulse", r);
            end else begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                if ({o.s, o.d, o.e} !== {e.s, e.d, e.e}) begin failures++; $display("FAIL stale_upd%0d: got %0d/%0d/%0d want %0d/%0d/%0d", r, o.s, o.d, o.e, e.s, e.d, e.e); end
                if (r == 1) begin
                    checks++; if (o.cyc != tfall + 2) begin failures++; $display("FAIL stale_restart: pulse at %0d want %0d", o.cyc, tfall + 2); end
                end
                for (int k = 0; k < 30 && busy !== 1'b0; k++) @(negedge clk);
                tfall = cyc;
                checks++; if (tfall - o.cyc != stub_delay + 1) begin failures++; $display("FAIL stale_early_done%0d: run took %0d want %0d", r, tfall - o.cyc, stub_delay + 1); end
            end
        end
        exp_runs += 2;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int u0, prev_cyc;
        upd_t o, e;
        stub_delay = 5;
        u0 = unstable_cnt;
        prev_cyc = -1;
        stage(6'd9, 6'd10);
        push_commit(32'd1000, 1'b1, 1'b1);
        push_commit(32'd2000, 1'b0, 1'b1);
        push_commit(32'd3000, 1'b0, 1'b1);
        for (int k = 0; k < 100 && obs_q.size() < 3; k++) @(negedge clk);
        checks++;
        if (obs_q.size() < 3) begin
            failures++; $display("FAIL b2b_pulses: got %0d want 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                checks++; if ({o.s, o.d, o.e} !== {e.s, e.d, e.e}) begin failures++; $display("FAIL b2b_order%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i, o.s, o.d, o.e, e.s, e.d, e.e); end
                if (e.cyc >= 0) begin
                    checks++; if (o.cyc != e.cyc) begin failures++; $display("FAIL b2b_latency: pulse at %0d want %0d", o.cyc, e.cyc); end
                end
                if (prev_cyc >= 0) begin
                    checks++; if (o.cyc - prev_cyc != stub_delay + 3) begin failures++; $display("FAIL b2b_spacing%0d: got %0d want %0d", i, o.cyc - prev_cyc, stub_delay + 3); end
                end
                prev_cyc = o.cyc;
            end
        end
        for (int k = 0; k < 40 && busy !== 1'b0; k++) @(negedge clk);
        checks++; if (unstable_cnt != u0) begin failures++; $display("FAIL b2b_stable: %0d endpoint changes outside LOAD want 0", unstable_cnt - u0); end
        exp_runs += 3;
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'(exp_runs)) begin failures++; $display("FAIL b2b_run_count: got %0d want %0d", rd, exp_runs); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        int p0;
        upd_t o, e;
        stub_en = 1'b0; stub_delay = 3;
        p0 = pulse_cnt;
        // First commit goes straight into the run, the next DEPTH fill the queue, the last is dropped.
        for (int i = 0; i < DEPTH + 2; i++) begin
            stage(PRED_W'(i+1), PRED_W'(i+33));
            push_commit(32'h100 + 32'(i), i == 0, i < DEPTH + 1);
        end
        repeat (2) @(negedge clk);
        bus_read(2'd0, rd);
        checks++; if (rd !== {exp_runs[15:0], 8'(DEPTH), 6'b0, 1'b1, 1'b1}) begin failures++; $display("FAIL ovf_status: got %h want %h", rd, {exp_runs[15:0], 8'(DEPTH), 6'b0, 1'b1, 1'b1}); end
        bus_write(2'd3, 32'd0);
        bus_read(2'd0, rd);
        checks++; if (rd !== {exp_runs[15:0], 8'(DEPTH), 6'b0, 1'b0, 1'b1}) begin failures++; $display("FAIL ovf_clear: got %h want %h", rd, {exp_runs[15:0], 8'(DEPTH), 6'b0, 1'b0, 1'b1}); end
        stub_en = 1'b1;
        for (int k = 0; k < 400 && obs_q.size() < DEPTH + 1; k++) @(negedge clk);
        checks++;
        if (obs_q.size() < DEPTH + 1) begin
            failures++; $display("FAIL ovf_drain: got %0d pulses want %0d", obs_q.size(), DEPTH + 1);
        end else begin
            for (int i = 0; i < DEPTH + 1; i++) begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                checks++; if ({o.s, o.d, o.e} !== {e.s, e.d, e.e}) begin failures++; $display("FAIL ovf_order%0d: got %0d/%0d/%h want %0d/%0d/%h", i, o.s, o.d, o.e, e.s, e.d, e.e); end
            end
        end
        for (int k = 0; k < 40 && busy !== 1'b0; k++) @(negedge clk);
        repeat (10) @(negedge clk);
        checks++; if (pulse_cnt - p0 != DEPTH + 1) begin failures++; $display("FAIL ovf_drop: got %0d runs want %0d", pulse_cnt - p0, DEPTH + 1); end
        exp_runs += DEPTH + 1;
    endtask

    task automatic test_readback();
        logic [31:0] rd;
        bus_write(2'd2, 32'd5);
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'd5 || src !== 6'd5) begin failures++; $display("FAIL rb_src: readdata=%0d src=%0d want 5/5", rd, src); end
        repeat (2) @(negedge clk);
        checks++; if (hb.readdata !== 32'd5) begin failures++; $display("FAIL rb_hold: got %0d want 5", hb.readdata); end
        bus_write(2'd2, 32'hFFFF_FFC7);
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'd7) begin failures++; $display("FAIL rb_src_zext: got %h want 00000007", rd); end
        bus_read(2'd3, rd);
        checks++; if (rd !== 32'd0) begin failures++; $display("FAIL rb_addr3: got %h want 0", rd); end
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'(exp_runs)) begin failures++; $display("FAIL rb_run_count: got %0d want %0d", rd, exp_runs); end
    endtask

    initial begin
        hb.write = 1'b0; hb.read = 1'b0; hb.address = 2'd0; hb.writedata = 32'd0;
        test_reset();
        test_single();
        test_stale_done();
        test_back_to_back();
        test_overflow();
        test_readback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
